// File: rtl/reset_pkg.sv
// reset_pkg: shared types and helpers for the clock/reset bring-up blocks
package reset_pkg;
    typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, FILTER, LOCKED, FAIL} pll_mon_state_t;

    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/bit_sync.sv
// bit_sync: STAGES-deep flop chain bringing an asynchronous bit into the clk domain
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk)
        ff <= rst ? '0 : ((ff << 1) | STAGES'(d));

    assign q = ff[STAGES-1];
endmodule

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: PLL reset/retry control and debounced lock for the reset sequencer
module pll_lock_monitor
    import reset_pkg::*;
#(
    parameter int LOCK_FILTER    = 64,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int MAX_RETRY      = 7,
    localparam int RW            = max_int(1, $clog2(MAX_RETRY + 1))
) (
    input  logic          clk,
    input  logic          sync_reset,
    input  logic          pll_locked_raw,
    input  logic          ext_reset_req,
    output logic          pll_reset,
    output logic          pll_locked,
    output logic          system_reset_req,
    output logic          lock_lost,
    output logic [RW-1:0] retry_count,
    output logic          fail
);
    localparam int CW = max_int(1, $clog2(max_int(LOCK_FILTER, max_int(PLL_RST_CYCLES, LOCK_TIMEOUT))));

    pll_mon_state_t state, state_n;
    logic [CW-1:0]  cnt;
    logic           lock_s;
    logic           retry_inc;

    bit_sync #(.STAGES(2)) u_sync (
        .clk (clk),
        .rst (sync_reset),
        .d   (pll_locked_raw),
        .q   (lock_s)
    );

    // A lock seen on the timeout cycle takes priority over the retry
    always_comb begin
        state_n   = state;
        retry_inc = 1'b0;
        case (state)
            PLL_RST:   if (cnt == CW'(PLL_RST_CYCLES - 1)) state_n = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s) state_n = FILTER;
                else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    retry_inc = retry_count != RW'(MAX_RETRY);
                    state_n   = retry_inc ? PLL_RST : FAIL;
                end
            end
            FILTER:    state_n = !lock_s ? WAIT_LOCK : (cnt == CW'(LOCK_FILTER - 1)) ? LOCKED : FILTER;
            LOCKED:    state_n = lock_s ? LOCKED : PLL_RST;
            default:   state_n = FAIL;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state            <= PLL_RST;
            cnt              <= '0;
            pll_reset        <= 1'b1;
            pll_locked       <= 1'b0;
            system_reset_req <= 1'b1;
            lock_lost        <= 1'b0;
            retry_count      <= '0;
            fail             <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= state_n != state ? '0 : cnt + 1'b1;
            pll_reset        <= state_n == PLL_RST || state_n == FAIL;
            pll_locked       <= state_n == LOCKED;
            system_reset_req <= state_n != LOCKED || ext_reset_req;
            lock_lost        <= lock_lost || (state == LOCKED && state_n == PLL_RST);
            retry_count      <= state_n == LOCKED ? '0 : retry_count + RW'(retry_inc);
            fail             <= fail || state_n == FAIL;
        end
    end
endmodule
